// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_e;

  localparam logic [7:0]  START_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned MAX_LEN            = 256;
  localparam logic [8:0]  MAX_LEN_COUNT      = 9'(MAX_LEN);

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes instruction bytes to consecutive addresses,
// checks a trailing checksum and holds the core in reset until a clean load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] START_BYTE = START_BYTE_DEFAULT,
  parameter int         ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [7:0]            byte_count
);

  state_e                state_q, state_d;
  logic [8:0]            remaining_q, remaining_d;
  logic [7:0]            sum_q, sum_d;
  logic                  in_ready_q, in_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;
  logic [7:0]            byte_count_q, byte_count_d;

  logic                  hs;
  logic [7:0]            csum_total;

  assign hs         = in_valid && in_ready_q;
  assign csum_total = sum_q + in_data;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    sum_d        = sum_q;
    in_ready_d   = 1'b1;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    // wr_addr points at the pending write and advances once that write is done
    wr_addr_d    = wr_en_q ? wr_addr_q + ADDR_WIDTH'(1) : wr_addr_q;
    cpu_hold_d   = cpu_hold_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    byte_count_d = byte_count_q;

    if (hs) begin
      case (state_q)
        IDLE: begin
          if (in_data == START_BYTE) state_d = LEN;
        end
        LEN: begin
          remaining_d  = (in_data == 8'd0) ? MAX_LEN_COUNT : {1'b0, in_data};
          sum_d        = in_data;
          wr_addr_d    = '0;
          byte_count_d = 8'd0;
          state_d      = DATA;
        end
        DATA: begin
          wr_en_d      = 1'b1;
          wr_data_d    = in_data;
          sum_d        = sum_q + in_data;
          remaining_d  = remaining_q - 9'd1;
          // Modulo-256 count: 0 alongside load_done means a full 256-byte image.
          byte_count_d = byte_count_q + 8'd1;
          if (remaining_q == 9'd1) state_d = CSUM;
        end
        CSUM: begin
          if (csum_total == 8'd0) begin
            state_d     = DONE;
            cpu_hold_d  = 1'b0;
            load_done_d = 1'b1;
          end else begin
            state_d      = ERROR;
            load_error_d = 1'b1;
          end
        end
        DONE, ERROR: begin
          if (in_data == START_BYTE) begin
            state_d      = LEN;
            cpu_hold_d   = 1'b1;
            load_done_d  = 1'b0;
            load_error_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      remaining_q  <= 9'd0;
      sum_q        <= 8'd0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'd0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      byte_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      sum_q        <= sum_d;
      in_ready_q   <= in_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as data bytes are
// driven and matched against wr_en/wr_addr/wr_data as the loader emits them.
module tb_imem_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       cpu_hold;
  logic       load_done;
  logic       load_error;
  logic [7:0] byte_count;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  payload[$];

  imem_loader #(.START_BYTE(8'hA5), .ADDR_WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error),
    .byte_count (byte_count)
  );

  always #5 clock = ~clock;

  // Write monitor: every memory write must match the oldest queued expectation.
  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%02h data=%02h, required no write", wr_addr, wr_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL write: got addr=%02h data=%02h, required addr=%02h data=%02h",
                   wr_addr, wr_data, e[15:8], e[7:0]);
        end else begin
          $display("write addr=%02h data=%02h ok", wr_addr, wr_data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    if (gap) begin
      in_valid = 1'b0;
      step();
    end
    in_data  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Sends START, LEN, payload, checksum; queues the expected writes.
  task automatic send_frame(input bit corrupt, input bit gap, input bit hold_check);
    int n;
    logic [7:0] s;
    logic [7:0] csum;
    n = payload.size();
    s = n[7:0];
    send_byte(8'hA5, gap);
    send_byte(n[7:0], gap);
    for (int i = 0; i < n; i++) begin
      s = s + payload[i];
      exp_q.push_back({i[7:0], payload[i]});
      send_byte(payload[i], gap);
      if (hold_check) begin
        checks++;
        if (cpu_hold !== 1'b1) begin
          errors++;
          $display("FAIL hold_during_frame: got cpu_hold=%b, required 1", cpu_hold);
        end
      end
    end
    csum = 8'd0 - s;
    if (corrupt) csum = csum + 8'd1;
    send_byte(csum, gap);
    $display("frame len=%0d csum=%02h sent", n, csum);
  endtask

  task automatic check_status(input string name, input logic done_e, input logic err_e,
                              input logic hold_e, input logic [7:0] cnt_e);
    checks++;
    if (load_done !== done_e || load_error !== err_e || cpu_hold !== hold_e ||
        byte_count !== cnt_e || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got done=%b err=%b hold=%b count=%0d pending=%0d, required done=%b err=%b hold=%b count=%0d pending=0",
               name, load_done, load_error, cpu_hold, byte_count, exp_q.size(),
               done_e, err_e, hold_e, cnt_e);
    end else begin
      $display("%s status ok", name);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) step();
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_error, byte_count}
        !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_values: got ready=%b wr_en=%b addr=%02h data=%02h hold=%b done=%b err=%b count=%0d, required 0 0 00 00 1 0 0 0",
               in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_error, byte_count);
    end else $display("reset values ok");
    in_valid = 1'b0;
    reset    = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, required 1", in_ready);
    end else $display("in_ready after reset ok");
  endtask

  task automatic test_good_load();
    payload = '{8'h11, 8'h22, 8'h33};
    send_frame(1'b0, 1'b0, 1'b0);
    check_status("good_load", 1'b1, 1'b0, 1'b0, 8'd3);
  endtask

  task automatic test_bad_checksum();
    payload = '{8'h10, 8'h20};
    send_frame(1'b1, 1'b0, 1'b0);
    check_status("bad_checksum", 1'b0, 1'b1, 1'b1, 8'd2);
  endtask

  task automatic test_garbage_gaps();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    check_status("garbage_ignored", 1'b0, 1'b1, 1'b1, 8'd2);
    payload = '{8'hA5};
    send_frame(1'b0, 1'b1, 1'b0);
    check_status("gapped_load", 1'b1, 1'b0, 1'b0, 8'd1);
  endtask

  task automatic test_full_256();
    payload.delete();
    for (int i = 0; i < 256; i++) payload.push_back(i[7:0]);
    send_frame(1'b0, 1'b0, 1'b0);
    check_status("full_256", 1'b1, 1'b0, 1'b0, 8'd0);
    checks++;
    if (wr_addr !== 8'h00) begin
      errors++;
      $display("FAIL addr_wrap: got wr_addr=%02h, required 00", wr_addr);
    end else $display("wr_addr wrapped to 00 ok");
  endtask

  task automatic test_back_to_back_restart();
    payload = '{8'h07};
    send_frame(1'b0, 1'b0, 1'b1);
    check_status("restart_from_done", 1'b1, 1'b0, 1'b0, 8'd1);
  endtask

  task automatic test_reset_mid_frame();
    payload = '{8'h01, 8'h02};
    send_byte(8'hA5, 1'b0);
    send_byte(8'h04, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({i[7:0], payload[i]});
      send_byte(payload[i], 1'b0);
    end
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_wr_en: got %b, required 0", wr_en);
    end else $display("abort dropped write ok");
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'hF2, 1'b0);
    step();
    check_status("aborted_frame", 1'b0, 1'b0, 1'b1, 8'd0);
    payload = '{8'h3C, 8'hC3, 8'h99, 8'h42};
    send_frame(1'b0, 1'b0, 1'b0);
    check_status("reload_after_abort", 1'b1, 1'b0, 1'b0, 8'd4);
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_garbage_gaps();
    test_full_256();
    test_back_to_back_restart();
    test_reset_mid_frame();
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: got %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
